det3x3_seq_ctrl: RTL and testbench

Sequential controller that computes the 3x3 determinant, modulo 256, through one shared 8x8 multiplier instead of nine parallel ones. The fully parallel combinational determinant costs too much area on the coprocessor FPGA. This block latches the nine matrix elements on a start handshake, performs nine multiply/accumulate steps, and returns the 8-bit wrapped result with a done pulse. It sits between the coprocessor instruction decoder and the arithmetic datapath.

---
 rtl/det_pkg.sv | 32 +++
 rtl/det_mul_unit.sv | 10 +
 rtl/det3x3_seq_ctrl.sv | 95 +++++++++
 tb/tb_det3x3_seq_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// det_pkg: shared encodings for the sequential 3x3 determinant controller.
package det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD,
        OP_SUB_COF,
        OP_ACC_ADD,
        OP_ACC_SUB,
        OP_FINAL
    } op_t;

    localparam logic [3:0] STEP_LAST = 4'd8;

    // Element index (row-major a..i = 0..8) feeding each multiplier port per step; 9 selects cof.
    localparam logic [3:0] OPA_IDX [9] = '{4'd4, 4'd5, 4'd0, 4'd3, 4'd5, 4'd1, 4'd3, 4'd4, 4'd2};
    localparam logic [3:0] OPB_IDX [9] = '{4'd8, 4'd7, 4'd9, 4'd8, 4'd6, 4'd9, 4'd7, 4'd6, 4'd9};
    localparam logic [3:0] SEL_COF = 4'd9;

    function automatic op_t step_op(input logic [3:0] s);
        return (s == STEP_LAST) ? OP_FINAL :
               (s == 4'd2) ? OP_ACC_ADD :
               (s == 4'd5) ? OP_ACC_SUB :
               (s == 4'd1 || s == 4'd4 || s == 4'd7) ? OP_SUB_COF : OP_LOAD;
    endfunction

endpackage

// File: rtl/det_mul_unit.sv
// det_mul_unit: combinational DATA_W x DATA_W multiplier returning the wrapped low DATA_W bits.
module det_mul_unit #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] p
);
    assign p = x * y;
endmodule

// File: rtl/det3x3_seq_ctrl.sv
// det3x3_seq_ctrl: 3x3 determinant mod 2^DATA_W via one shared multiplier, nine steps per result.
// Multiplier operands are registered, so step k's product is applied one cycle after it is selected.
module det3x3_seq_ctrl
    import det_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int N_STEPS = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] e,
    input  logic [DATA_W-1:0] f,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] h,
    input  logic [DATA_W-1:0] i,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] resultado
);
    localparam logic [3:0] STEP_END = 4'(N_STEPS);

    state_t            state, state_n;
    logic [3:0]        step;
    logic [DATA_W-1:0] m [9];
    logic [DATA_W-1:0] opa, opb, cof, acc, p;
    logic [DATA_W-1:0] cof_n, acc_n, na, nb;
    logic [3:0]        ls;
    logic              apply;
    op_t               op;

    det_mul_unit #(.DATA_W(DATA_W)) u_mul (.x(opa), .y(opb), .p(p));

    always_comb begin
        op    = step_op(step - 4'd1);
        apply = (state == CALC) && (step != 4'd0);
        cof_n = (op == OP_LOAD) ? p : (op == OP_SUB_COF) ? cof - p : cof;
        acc_n = (op == OP_ACC_ADD) ? acc + p : (op == OP_ACC_SUB) ? acc - p : acc;
        ls    = (step >= STEP_END) ? 4'd0 : step;
        na    = m[OPA_IDX[ls]];
        // Cofactor operand must see the value being written this same edge.
        nb    = (OPB_IDX[ls] == SEL_COF) ? (apply ? cof_n : cof) : m[OPB_IDX[ls]];
    end

    always_comb begin
        state_n = state;
        busy    = (state == CALC);
        done    = (state == DONE);
        if (state == IDLE && start)
            state_n = CALC;
        else if (state == CALC && step == STEP_END)
            state_n = DONE;
        else if (state == DONE)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step      <= '0;
            m         <= '{default: '0};
            opa       <= '0;
            opb       <= '0;
            cof       <= '0;
            acc       <= '0;
            resultado <= '0;
        end else if (state == IDLE && start) begin
            m    <= '{a, b, c, d, e, f, g, h, i};
            step <= '0;
            cof  <= '0;
            acc  <= '0;
        end else if (state == CALC) begin
            step <= step + 4'd1;
            opa  <= na;
            opb  <= nb;
            if (apply) begin
                cof <= cof_n;
                acc <= acc_n;
                if (op == OP_FINAL)
                    resultado <= acc + p;
            end
        end
    end

endmodule

// File: tb/tb_det3x3_seq_ctrl.sv
// tb_det3x3_seq_ctrl: directed vector table, multi-cycle corner sequences and a random sweep.
module tb_det3x3_seq_ctrl;
    typedef logic [7:0] mat_t [9];
    typedef struct {
        mat_t       m;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic [7:0] a, b, c, d, e, f, g, h, i;
    logic       busy, done;
    logic [7:0] resultado;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    det3x3_seq_ctrl #(.DATA_W(8), .N_STEPS(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
        .busy(busy), .done(done), .resultado(resultado)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] det_ref(input mat_t x);
        int v;
        v = int'(x[0]) * (int'(x[4]) * int'(x[8]) - int'(x[5]) * int'(x[7]))
          - int'(x[1]) * (int'(x[3]) * int'(x[8]) - int'(x[5]) * int'(x[6]))
          + int'(x[2]) * (int'(x[3]) * int'(x[7]) - int'(x[4]) * int'(x[6]));
        return v[7:0];
    endfunction

    task automatic set_m(input mat_t x);
        {a, b, c, d, e, f, g, h, i} = {x[0], x[1], x[2], x[3], x[4], x[5], x[6], x[7], x[8]};
    endtask

    task automatic launch(input mat_t x);
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        set_m(x);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("accept_busy", busy, 1);
    endtask

    // Samples #1 after each edge following the accept edge; optionally pokes start and new operands.
    task automatic wait_done(input bit poke, output int lat, output bit busy_ok);
        mat_t idm = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (poke) begin
                @(negedge clk);
                start = (k <= 9);
                if (k <= 9) set_m(idm);
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_check(input string name, input mat_t x, input logic [7:0] exp);
        int lat;
        bit bok;
        launch(x);
        wait_done(1'b0, lat, bok);
        chk({name, "_latency"}, lat, 10);
        chk({name, "_busy_hold"}, bok, 1);
        chk({name, "_busy_at_done"}, busy, 0);
        chk({name, "_result"}, resultado, exp);
    endtask

    vec_t tbl [7];
    mat_t va = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd91};
    mat_t vd = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd4};
    mat_t vi = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    mat_t vr;

    initial begin
        int lat, gap, cnt;
        bit bok;
        tbl[0] = '{m: vi, exp: 8'h01};
        tbl[1] = '{m: '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, exp: 8'h00};
        tbl[2] = '{m: vd, exp: 8'h18};
        tbl[3] = '{m: '{8'd8, 8'd0, 8'd0, 8'd0, 8'd8, 8'd0, 8'd0, 8'd0, 8'd8}, exp: 8'h00};
        tbl[4] = '{m: '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1}, exp: 8'hFF};
        tbl[5] = '{m: '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd4, 8'd5, 8'd6, 8'd0}, exp: 8'h01};
        tbl[6] = '{m: va, exp: 8'hD4};
        set_m(vi);

        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", resultado, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) run_check($sformatf("vec%0d", k), tbl[k].m, tbl[k].exp);

        // Extra start and operand changes while computing are ignored.
        launch(va);
        wait_done(1'b1, lat, bok);
        start = 1'b0;
        chk("ignore_latency", lat, 10);
        chk("ignore_result", resultado, 8'hD4);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1 cnt += int'(done) + int'(busy);
        end
        chk("ignore_no_requeue", cnt, 0);

        // start held high: next accept comes once the controller is back in IDLE.
        launch(vd);
        start = 1'b1;
        wait_done(1'b0, lat, bok);
        chk("b2b_first_result", resultado, 8'h18);
        @(negedge clk);
        set_m(vi);
        gap = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                gap = k;
                break;
            end
        end
        start = 1'b0;
        chk("b2b_accept_gap", gap, 2);
        @(posedge clk);
        #1 chk("b2b_result_held", resultado, 8'h18);
        wait_done(1'b0, lat, bok);
        chk("b2b_second_latency", lat, 9);
        chk("b2b_second_result", resultado, 8'h01);

        // Reset while computing step 4 aborts with no done pulse.
        launch(va);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", resultado, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1 cnt += int'(done);
        end
        chk("abort_no_done", cnt, 0);
        run_check("after_abort", va, 8'hD4);

        for (int n = 0; n < 1000; n++) begin
            foreach (vr[k]) vr[k] = 8'($urandom_range(0, 255));
            launch(vr);
            wait_done(1'b0, lat, bok);
            chk("random_result", resultado, det_ref(vr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
